// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter_pkg: register indices, claim valid bit position and bus FSM states
package irq_arbiter_pkg;
  localparam logic [2:0] IRQA_ADDR_MODE    = 3'd0;
  localparam logic [2:0] IRQA_ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] IRQA_ADDR_PENDING = 3'd2;
  localparam logic [2:0] IRQA_ADDR_CLAIM   = 3'd3;
  localparam logic [2:0] IRQA_ADDR_SET     = 3'd4;
  localparam int IRQA_CLAIM_VALID_BIT = 31;
  typedef enum logic {ST_IDLE, ST_ACK} state_t;
endpackage

// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: single-strobe register bus between a master and the arbiter
interface irq_arbiter_if #(parameter int DATA_W = 32) ();
  logic req;
  logic we;
  logic [2:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic ack;
  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder
module irq_prio_enc #(
  parameter int CH = 8
) (
  input  logic [CH-1:0]         v,
  output logic [$clog2(CH)-1:0] id,
  output logic                  valid
);
  localparam int IW = $clog2(CH);
  always_comb begin
    id = '0;
    for (int i = CH - 1; i >= 0; i--) id = v[i] ? IW'(i) : id;
  end
  assign valid = |v;
endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: synchronizes, latches and gates interrupt sources behind a claimable register port
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int CH     = 8,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] src,
  irq_arbiter_if.slave  bus,
  output logic [CH-1:0] irq
);
  logic [CH-1:0] s0, s1, s2, mode, enable, pending;
  logic [CH-1:0] rise, set_w, clr_w, claim_oh;
  logic [$clog2(CH)-1:0] id;
  logic valid, acc, wr;
  logic [DATA_W-1:0] rd_val;
  state_t state;
  irq_prio_enc #(.CH(CH)) u_enc (.v(irq), .id(id), .valid(valid));
  assign irq = pending & enable;
  assign acc = state == ST_IDLE && bus.req;
  assign wr  = acc && bus.we;
  always_comb begin
    rise     = s1 & ~s2;
    set_w    = (wr && bus.addr == IRQA_ADDR_SET) ? bus.wdata[CH-1:0] : '0;
    clr_w    = (wr && bus.addr == IRQA_ADDR_PENDING) ? bus.wdata[CH-1:0] : '0;
    claim_oh = (acc && !bus.we && bus.addr == IRQA_ADDR_CLAIM && valid) ? {{(CH-1){1'b0}}, 1'b1} << id : '0;
    rd_val   = bus.addr == IRQA_ADDR_MODE    ? DATA_W'(mode) :
               bus.addr == IRQA_ADDR_ENABLE  ? DATA_W'(enable) :
               bus.addr == IRQA_ADDR_PENDING ? DATA_W'(pending) :
               (bus.addr == IRQA_ADDR_CLAIM && valid) ? ((DATA_W'(1) << IRQA_CLAIM_VALID_BIT) | DATA_W'(id)) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s0        <= '0;
      s1        <= '0;
      s2        <= '0;
      mode      <= '0;
      enable    <= '0;
      pending   <= '0;
      state     <= ST_IDLE;
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      s0        <= src;
      s1        <= s0;
      s2        <= s1;
      // new events win over clears on edge channels; level channels track s1
      pending   <= (mode & ((pending & ~(clr_w | claim_oh)) | rise | set_w)) | (~mode & s1);
      mode      <= (wr && bus.addr == IRQA_ADDR_MODE) ? bus.wdata[CH-1:0] : mode;
      enable    <= (wr && bus.addr == IRQA_ADDR_ENABLE) ? bus.wdata[CH-1:0] : enable;
      state     <= acc ? ST_ACK : ST_IDLE;
      bus.ack   <= acc;
      bus.rdata <= (acc && !bus.we) ? rd_val : '0;
    end
  end
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed stimulus with a queue-based scoreboard on the bus acknowledge
module tb_irq_arbiter;
  import irq_arbiter_pkg::*;
  typedef struct {
    logic        chk;
    logic [31:0] v;
    string       name;
  } exp_t;
  logic clk, reset;
  logic [7:0] src, irq;
  irq_arbiter_if #(.DATA_W(32)) bus ();
  exp_t q[$];
  int checks = 0, errors = 0, ack_cnt = 0, exp_acks = 0;
  irq_arbiter #(.CH(8), .DATA_W(32)) dut (.clk(clk), .reset(reset), .src(src), .bus(bus), .irq(irq));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic access(input logic w, input logic [2:0] a, input logic [31:0] d,
                        input logic [31:0] e, input string nm, input int irq_exp = -1);
    q.push_back('{chk: !w, v: e, name: nm});
    exp_acks++;
    bus.req = 1'b1;
    bus.we = w;
    bus.addr = a;
    bus.wdata = d;
    step();
    bus.req = 1'b0;
    if (irq_exp >= 0) chk({nm, "_irq_at_ack"}, 32'(irq), irq_exp[31:0]);
    step();
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (bus.ack) begin
      ack_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack");
      end else begin
        x = q.pop_front();
        if (x.chk) chk(x.name, bus.rdata, x.v);
      end
    end else if (!reset) chk("rdata_idle_zero", bus.rdata, 32'h0);
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    reset = 1'b1;
    src = '0;
    bus.req = 1'b0;
    bus.we = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    repeat (3) step();
    reset = 1'b0;
    chk("reset_irq", 32'(irq), 32'h0);
    access(0, IRQA_ADDR_MODE, 0, 32'h0, "reset_mode");
    access(0, IRQA_ADDR_ENABLE, 0, 32'h0, "reset_enable");
    access(0, IRQA_ADDR_PENDING, 0, 32'h0, "reset_pending");
    access(0, IRQA_ADDR_CLAIM, 0, 32'h0, "reset_claim");
    access(0, IRQA_ADDR_SET, 0, 32'h0, "set_reads_zero");
    access(0, 3'd5, 0, 32'h0, "reserved_read");
    access(1, 3'd6, 32'hFF, 32'h0, "reserved_write");
    access(0, IRQA_ADDR_MODE, 0, 32'h0, "mode_after_reserved_write");
    access(1, IRQA_ADDR_MODE, 32'h05, 32'h0, "wr_mode");
    access(1, IRQA_ADDR_ENABLE, 32'hFF, 32'h0, "wr_enable");
    access(0, IRQA_ADDR_MODE, 0, 32'h05, "rd_mode");
    src[2] = 1'b1;
    step();
    chk("edge_irq_e1", 32'(irq), 32'h0);
    step();
    chk("edge_irq_e2", 32'(irq), 32'h0);
    src[2] = 1'b0;
    step();
    chk("edge_irq_e3", 32'(irq), 32'h04);
    access(0, IRQA_ADDR_PENDING, 0, 32'h04, "edge_pending");
    access(0, IRQA_ADDR_CLAIM, 0, 32'h8000_0002, "edge_claim", 0);
    access(0, IRQA_ADDR_PENDING, 0, 32'h0, "edge_pending_cleared");
    access(1, IRQA_ADDR_MODE, 32'h0, 32'h0, "lvl_mode");
    access(1, IRQA_ADDR_ENABLE, 32'h02, 32'h0, "lvl_enable");
    src[1] = 1'b1;
    repeat (4) step();
    chk("lvl_irq_high", 32'(irq), 32'h02);
    access(1, IRQA_ADDR_PENDING, 32'h02, 32'h0, "lvl_clear", 2);
    chk("lvl_irq_after_clear", 32'(irq), 32'h02);
    src[1] = 1'b0;
    step();
    chk("lvl_fall_e1", 32'(irq), 32'h02);
    step();
    chk("lvl_fall_e2", 32'(irq), 32'h02);
    step();
    chk("lvl_fall_e3", 32'(irq), 32'h0);
    access(1, IRQA_ADDR_MODE, 32'hFF, 32'h0, "prio_mode");
    access(1, IRQA_ADDR_ENABLE, 32'hFF, 32'h0, "prio_enable");
    access(1, IRQA_ADDR_SET, 32'h48, 32'h0, "prio_set");
    chk("prio_irq", 32'(irq), 32'h48);
    access(0, IRQA_ADDR_CLAIM, 0, 32'h8000_0003, "prio_claim1", 32'h40);
    access(0, IRQA_ADDR_CLAIM, 0, 32'h8000_0006, "prio_claim2", 0);
    access(0, IRQA_ADDR_CLAIM, 0, 32'h0, "prio_claim3");
    access(1, IRQA_ADDR_ENABLE, 32'h40, 32'h0, "gate_enable");
    access(1, IRQA_ADDR_SET, 32'h48, 32'h0, "gate_set");
    chk("gate_irq", 32'(irq), 32'h40);
    access(0, IRQA_ADDR_CLAIM, 0, 32'h8000_0006, "gate_claim", 0);
    access(0, IRQA_ADDR_PENDING, 0, 32'h08, "gate_pending");
    access(1, IRQA_ADDR_PENDING, 32'h08, 32'h0, "gate_clear");
    access(0, IRQA_ADDR_PENDING, 0, 32'h0, "gate_pending_cleared");
    src[0] = 1'b1;
    step();
    step();
    access(1, IRQA_ADDR_PENDING, 32'h01, 32'h0, "sim_clear_at_rise");
    access(0, IRQA_ADDR_PENDING, 0, 32'h01, "sim_pending_kept");
    src[0] = 1'b0;
    access(1, IRQA_ADDR_PENDING, 32'h01, 32'h0, "sim_clear");
    access(0, IRQA_ADDR_PENDING, 0, 32'h0, "sim_pending_cleared");
    q.push_back('{chk: 1'b0, v: 32'h0, name: "held_req"});
    exp_acks++;
    bus.req = 1'b1;
    bus.we = 1'b1;
    bus.addr = IRQA_ADDR_ENABLE;
    bus.wdata = 32'h11;
    step();
    bus.wdata = 32'h22;
    step();
    bus.req = 1'b0;
    chk("held_no_second_ack", 32'(bus.ack), 32'h0);
    step();
    access(0, IRQA_ADDR_ENABLE, 0, 32'h11, "held_enable");
    bus.req = 1'b1;
    bus.we = 1'b1;
    bus.addr = IRQA_ADDR_ENABLE;
    bus.wdata = 32'hAA;
    reset = 1'b1;
    step();
    bus.req = 1'b0;
    chk("rst_abort_ack0", 32'(bus.ack), 32'h0);
    reset = 1'b0;
    step();
    chk("rst_abort_ack1", 32'(bus.ack), 32'h0);
    chk("rst_abort_irq", 32'(irq), 32'h0);
    access(0, IRQA_ADDR_MODE, 0, 32'h0, "rst_mode");
    access(0, IRQA_ADDR_ENABLE, 0, 32'h0, "rst_enable");
    access(0, IRQA_ADDR_PENDING, 0, 32'h0, "rst_pending");
    repeat (3) step();
    chk("queue_empty", 32'(q.size()), 32'h0);
    chk("ack_count", 32'(ack_cnt), 32'(exp_acks));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Interrupt source arbiter and configurator that sits between SoC peripherals and the CPU control block's `irq` input. It does four things:
- synchronizes raw peripheral interrupt lines;
- latches them as edge- or level-triggered pending bits;
- gates them with a per-channel enable;
- presents the result to the CPU.

A small register-mapped slave port lets software configure channels and claim the highest-priority pending channel, using a fixed lowest-index-wins priority.

## Interface
Parameters:
- `CH`, 8, number of interrupt channels; equals `CPU_IRQ_CH`.
- `DATA_W`, 32, bus data width; equals `WORD_DATA_W`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `src`  in  CH  raw peripheral interrupt lines, asynchronous to `clk`.
- `req`  in  1  bus access request; single-cycle strobe.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  3  register index; sampled with `req`.
- `wdata`  in  DATA_W  write data; sampled with `req`.
- `rdata`  out  DATA_W  read data; valid while `ack` = 1, otherwise 0.
- `ack`  out  1  access complete; one-cycle pulse.
- `irq`  out  CH  to the CPU `irq` input; equals `pending & enable`.

## Operation
- **Synchronizer:** s0 <= src, s1 <= s0, s2 <= s1. rise = s1 & ~s2.
- **Edge channel (mode bit = 1):** pending bit sets on rise. It clears only by a PENDING write-1, or by a CLAIM read that returns that channel.
- **Level channel (mode bit = 0):** pending bit <= s1 every cycle. Clear and SET writes have no effect on it.
- **Register map** (unused bits read 0; writes to them are ignored):
  - 0 MODE, R/W, CH bits.
  - 1 ENABLE, R/W, CH bits.
  - 2 PENDING. Read returns the pending bits. Write 1 clears edge channels.
  - 3 CLAIM, read-only. Returns {valid at bit 31, zeros, id at [2:0]}. id is the lowest index with `pending & enable` set. If none is set, the read returns 0 and has no side effect. If the claimed channel is an edge channel, its pending bit clears on the ack cycle.
  - 4 SET, write-only, reads 0. Write 1 sets pending for edge channels (software trigger).
  - 5–7 reserved. Reads return 0, writes are ignored, and `ack` is still given.
- **Bus FSM** (two states):
  - IDLE: `req` = 1 → ACK. The access is performed at this edge: registers are updated and `rdata` is captured.
  - ACK: `ack` = 1 for exactly one cycle, then → IDLE. A `req` seen in ACK is ignored, so the master must hold off for one cycle.
- **Pending update precedence** within one clock, per edge channel:
  - hardware rise or SET-write beats PENDING-clear or claim-clear, so the new event is not lost;
  - otherwise clear beats hold.
- **MODE change:**
  - switching level → edge keeps the current pending value;
  - switching edge → level makes pending follow s1 from the next cycle.
- **Reset values:** MODE = 0 (all level), ENABLE = 0, pending = 0, s0/s1/s2 = 0, FSM = IDLE, `ack` = 0, `rdata` = 0, `irq` = 0.
- **Reset mid-access:** the access is aborted and no `ack` is issued.

## Timing
- `src` rising before clock edge E1: s1 = 1 after E2, pending = 1 after E3, `irq` high in the cycle after E3. Latency is 3 clocks.
- Bus access: `req` sampled at edge N → `ack` and `rdata` valid in cycle N+1. Register side effects are visible from cycle N+1.
- A CLAIM read updates pending at edge N, so `irq` drops in cycle N+1, the same cycle as `ack`.
- `src` pulses must be at least 2 `clk` periods wide to be captured.
- `irq` is combinational from registered pending/enable, so there is no extra register stage.

## Structure
- A shared package / header `irq_arbiter.h` holds the register index constants (`IRQA_ADDR_MODE` … `IRQA_ADDR_SET`), the CLAIM valid bit position, and the FSM state encodings.
- One sub-module, `irq_prio_enc`: a CH-wide lowest-index priority encoder that outputs id and valid. It is combinational and is reused by the CLAIM read path.
- Synchronizer, pending logic and FSM stay in the top module.

## Test plan
- Reset, then read all registers → MODE/ENABLE/PENDING/CLAIM read 0, `irq` = 0, `ack` seen once per `req`.
- Edge channels:
  - stimulus: MODE = 0x05, ENABLE = 0xFF, then pulse `src[2]` for 2 clocks;
  - required: `irq` = 0x04 exactly 3 clocks after the rise;
  - required: CLAIM returns 0x8000_0002;
  - required: `irq` = 0 from the `ack` cycle.
- Level channel:
  - stimulus: MODE = 0, ENABLE = 0x02, hold `src[1]` = 1;
  - required: PENDING-clear write with 0x02 leaves `irq` = 0x02;
  - required: `irq` drops 3 clocks after `src[1]` falls.
- Priority:
  - stimulus: channels 6 and 3 pending and enabled;
  - required: first CLAIM → id 3, second → id 6, third → 0x0000_0000.
- Simultaneous events:
  - stimulus: edge channel 0, a hardware rise at the same edge as a PENDING write of 0x01;
  - required: pending[0] = 1 afterward.
- Protocol:
  - stimulus: `req` held high 2 cycles;
  - required: a single `ack`, and the second request is ignored.
  - stimulus: reset asserted the cycle after `req`;
  - required: no `ack`, all registers at reset values.
